// File: rtl/gb_vector_loader_if.sv
// Stream-in and GB-write bundle for gb_vector_loader. The master side is the loader;
// the slave side is the upstream source and the compute stage.
interface gb_vector_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  gb_we;
  logic [ADDR_WIDTH-1:0] gb_addr;
  logic [DATA_WIDTH-1:0] gb_data;
  logic                  start;
  logic                  done;
  logic                  busy;
  logic                  err_len;

  modport master (
    input  s_valid, s_data, s_last, done,
    output s_ready, gb_we, gb_addr, gb_data, start, busy, err_len
  );

  modport slave (
    output s_valid, s_data, s_last, done,
    input  s_ready, gb_we, gb_addr, gb_data, start, busy, err_len
  );
endinterface

// File: rtl/gb_vector_loader.sv
// Streams one Q8.8 vector into the global buffer, zero-pads short frames, flags
// length errors, then hands the vector to the compute stage with a start pulse.
module gb_vector_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int VECTOR_LEN = 100,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  gb_vector_loader_if.master   bus
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    FILL  = 3'd1,
    ARM   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_LEN - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  start_r;
  logic                  busy_r;
  logic                  err_r;
  logic                  accept;

  // Ready depends on state alone so upstream never sees a combinational path from valid.
  assign bus.s_ready = (state == LOAD);
  assign accept      = bus.s_valid && (state == LOAD);

  assign bus.gb_we   = we_r;
  assign bus.gb_addr = addr_r;
  assign bus.gb_data = data_r;
  assign bus.start   = start_r;
  assign bus.busy    = busy_r;
  assign bus.err_len = err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      we_r    <= 1'b0;
      start_r <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            we_r   <= 1'b1;
            addr_r <= cnt;
            data_r <= bus.s_data;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
              // Words beyond VECTOR_LEN stay in the stream for the next frame.
              state  <= ARM;
              busy_r <= 1'b1;
              if (!bus.s_last) err_r <= 1'b1;
            end else if (bus.s_last) begin
              state  <= FILL;
              busy_r <= 1'b1;
              err_r  <= 1'b1;
            end
          end
        end
        FILL: begin
          we_r   <= 1'b1;
          addr_r <= cnt;
          data_r <= '0;
          if (cnt == LAST_ADDR) state <= ARM;
          else                  cnt   <= cnt + 1'b1;
        end
        ARM: begin
          // The final write is on the bus this cycle; start follows once it has committed.
          state   <= START;
          start_r <= 1'b1;
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.done) begin
            cnt    <= '0;
            state  <= LOAD;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= LOAD;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_vector_loader.sv
// Table-driven frame bench for gb_vector_loader with a GB write monitor, plus a
// hand-written mid-frame reset sequence.
module tb_gb_vector_loader;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int VL = 100;

  typedef struct {
    string      name;
    int         n_beats;
    int         last_idx;   // -1: s_last never asserted
    int         kind;       // 0: reference Q8.8 pattern, 1: base + index
    logic [15:0] base;
    logic       do_reset;
    logic       exp_err;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gb_vector_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  gb_vector_loader #(.DATA_WIDTH(DW), .VECTOR_LEN(VL), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // GB write monitor, sampled on the falling edge
  int          cyc = 0;
  logic [15:0] mem [0:127];
  int          wr_stamp [0:127];
  int          wr_count = 0;
  int          start_count = 0;
  int          start_cyc = 0;
  int          wr_last_cyc = 0;
  int          run_start_cyc = 0;
  logic [6:0]  run_start_addr = '0;
  int          gap_err = 0;
  logic        prev_we = 1'b0;
  logic [6:0]  prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.gb_we) begin
      mem[bus.gb_addr] = bus.gb_data;
      wr_count = wr_count + 1;
      wr_stamp[bus.gb_addr] = wr_count;
      if (bus.gb_addr == 7'(VL - 1)) wr_last_cyc = cyc;
      if (!prev_we) begin
        run_start_cyc  = cyc;
        run_start_addr = bus.gb_addr;
      end else if (bus.gb_addr != prev_addr + 7'd1) begin
        gap_err = gap_err + 1;
      end
      prev_addr = bus.gb_addr;
    end
    if (bus.start) begin
      start_count = start_count + 1;
      start_cyc   = cyc;
    end
    prev_we = bus.gb_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int kind, input logic [15:0] base, input int i);
    logic [15:0] v;
    if (kind == 0) begin
      case (i % 5)
        0: v = 16'h0080;
        1: v = 16'h0020;
        2: v = 16'h0040;
        3: v = 16'h0100;
        default: v = 16'h00A0;
      endcase
    end else begin
      v = base + 16'(i);
    end
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    bus.done    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_gb_we",   32'(bus.gb_we),   32'd0);
    check("rst_gb_addr", 32'(bus.gb_addr), 32'd0);
    check("rst_gb_data", 32'(bus.gb_data), 32'd0);
    check("rst_start",   32'(bus.start),   32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_err_len", 32'(bus.err_len), 32'd0);
    rst = 1'b0;
  endtask

  // Offers beats while ready; returns after n beats were accepted (or a cycle budget ran out).
  task automatic send_beats(input int n, input int last_idx, input int kind, input logic [15:0] base);
    int i = 0;
    int guard = 0;
    logic acc;
    while (i < n && guard < 1000) begin
      acc = bus.s_ready;
      bus.s_valid = 1'b1;
      bus.s_data  = pat(kind, base, i);
      bus.s_last  = (i == last_idx);
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    check("beats_accepted", 32'(i), 32'(n));
  endtask

  task automatic run_frame(input frame_t f);
    int wc0, sc0, ge0, k, bad, ready_bad, busy_bad, n_data;
    logic [15:0] exp_v;
    if (f.do_reset) do_reset();
    wc0 = wr_count;
    sc0 = start_count;
    ge0 = gap_err;
    n_data = (f.n_beats < VL) ? f.n_beats : VL;
    send_beats(f.n_beats, f.last_idx, f.kind, f.base);
    // Keep offering a word that must not be taken until done.
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hBEEF;
    bus.s_last  = 1'b1;
    k = 0;
    while (start_count == sc0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    ready_bad = 0;
    busy_bad  = 0;
    repeat (50) begin
      if (bus.s_ready !== 1'b0) ready_bad++;
      if (bus.busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
    end
    check({f.name, "_start_once"},  32'(start_count - sc0), 32'd1);
    check({f.name, "_wr_count"},    32'(wr_count - wc0), 32'(VL));
    check({f.name, "_addr_gaps"},   32'(gap_err - ge0), 32'd0);
    check({f.name, "_first_addr"},  32'(run_start_addr), 32'd0);
    check({f.name, "_contiguous"},  32'(wr_last_cyc - run_start_cyc), 32'(VL - 1));
    check({f.name, "_start_after"}, 32'(start_cyc - wr_last_cyc), 32'd1);
    check({f.name, "_err_len"},     32'(bus.err_len), 32'(f.exp_err));
    check({f.name, "_wait_ready"},  32'(ready_bad), 32'd0);
    check({f.name, "_wait_busy"},   32'(busy_bad), 32'd0);
    bad = 0;
    for (int a = 0; a < VL; a++) begin
      exp_v = (a < n_data) ? pat(f.kind, f.base, a) : 16'h0000;
      if (mem[a] !== exp_v || wr_stamp[a] <= wc0) bad++;
    end
    check({f.name, "_gb_contents"}, 32'(bad), 32'd0);
    bus.done = 1'b1;
    @(posedge clk);
    #1;
    bus.done    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check({f.name, "_ready_after_done"}, 32'(bus.s_ready), 32'd1);
    check({f.name, "_busy_after_done"},  32'(bus.busy), 32'd0);
    check({f.name, "_no_stray_write"},   32'(wr_count - wc0), 32'(VL));
  endtask

  frame_t frames [6];
  frame_t fresh;
  int wc_m, sc_m;

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    bus.done    = 1'b0;

    frames[0] = '{"full",       100,  99, 0, 16'h0000, 1'b1, 1'b0};
    frames[1] = '{"second",     100,  99, 1, 16'h1000, 1'b0, 1'b0};
    frames[2] = '{"short60",     60,  59, 1, 16'h2200, 1'b1, 1'b1};
    frames[3] = '{"long_nolast",100,  -1, 1, 16'h3300, 1'b1, 1'b1};
    frames[4] = '{"short1",       1,   0, 1, 16'h7F01, 1'b1, 1'b1};
    frames[5] = '{"short99",     99,  98, 1, 16'hFF80, 1'b1, 1'b1};

    for (int f = 0; f < 6; f++) run_frame(frames[f]);

    // Reset in the middle of a frame
    do_reset();
    wc_m = wr_count;
    sc_m = start_count;
    send_beats(37, -1, 1, 16'h5500);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_s_ready", 32'(bus.s_ready), 32'd1);
    check("midrst_gb_we",   32'(bus.gb_we),   32'd0);
    check("midrst_start",   32'(bus.start),   32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_start", 32'(start_count - sc_m), 32'd0);
    check("midrst_writes",   32'(wr_count - wc_m), 32'd37);
    fresh = '{"fresh", 100, 99, 1, 16'h0A00, 1'b0, 1'b0};
    run_frame(fresh);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_vector_loader.md
# gb_vector_loader

Upstream feeder for the LSTM `top` datapath. It accepts one Q8.8 input vector at a time as a valid/ready stream and writes it word-by-word into the global buffer (GB) write port (`we`/`gb_data_addr`/`data_in`). Once the vector is complete it issues a single-cycle `start` to the compute stage, then holds off new input until `done` returns. Short frames are zero-padded to full length and flagged; long frames are truncated and flagged.

## Interface
- `DATA_WIDTH`, 16, word width (Q8.8 fixed point).
- `VECTOR_LEN`, 100, words per vector (equals `top` `MATRIX_COLS`); must be ≥2.
- `ADDR_WIDTH`, 7, GB address width; 2^ADDR_WIDTH ≥ VECTOR_LEN.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  DATA_WIDTH  input word.
- `s_last`  in  1  marks the final word of a vector.
- `gb_we`  out  1  GB write enable (drives `top.we`).
- `gb_addr`  out  ADDR_WIDTH  GB write address (drives `top.gb_data_addr`).
- `gb_data`  out  DATA_WIDTH  GB write data (drives `top.data_in`).
- `start`  out  1  one-cycle pulse: vector resident in GB.
- `done`  in  1  compute stage finished with the current vector.
- `busy`  out  1  high in every state except LOAD.
- `err_len`  out  1  sticky frame-length error.

## Operation
- Reset values: state=LOAD, cnt=0, `s_ready`=1, `gb_we`=0, `gb_addr`=0, `gb_data`=0, `start`=0, `busy`=0, `err_len`=0.
- A beat is accepted when `s_valid && s_ready`.
- States:
  - LOAD: `s_ready`=1. Each accepted beat writes `s_data` to address cnt, then cnt increments.
    - Accepted beat at cnt=VECTOR_LEN-1: go to ARM. If `s_last`=0, set `err_len`; the stream's subsequent words are not consumed by this frame.
    - Accepted beat with `s_last`=1 at cnt<VECTOR_LEN-1: set `err_len` and go to FILL.
  - FILL: `s_ready`=0. Writes 0 to addresses cnt+1 … VECTOR_LEN-1, one per cycle, then goes to ARM.
  - ARM: one cycle, `s_ready`=0. This is the cycle in which the final `gb_we` is high.
  - START: `start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: `s_ready`=0. When `done`=1 is sampled, set cnt=0 and go to LOAD.
- `done` is ignored in every state except WAIT.
- `err_len` clears only on `rst`.
- `gb_addr`/`gb_data` hold their last written values while `gb_we`=0.
- Assertion of `rst` in any state aborts the frame immediately and restores reset values. Words already written to the GB are not cleared.

## Timing
- Write latency: beat accepted at edge k → `gb_we`=1 with matching `gb_addr`/`gb_data` during the cycle after edge k.
- `gb_we` outputs are registered. Back-to-back beats produce contiguous `gb_we` cycles with incrementing addresses.
- A full-length frame streamed with `s_valid` held high takes VECTOR_LEN cycles of `s_ready`=1.
- The final write is visible in the ARM cycle. `start` follows one cycle later, so the GB write has committed before `start`.
- FILL adds VECTOR_LEN-1-cnt_last cycles, where cnt_last is the address of the last word in the short frame.
- `s_ready` is a function of the current state only (combinational from state). The earliest re-acceptance is the cycle after `done` is sampled in WAIT.
- `start` to next `s_ready`=1: at least 2 cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles → all outputs at reset values and `s_ready`=1.
- Full frame: 100 beats of the repeating pattern 0x0080, 0x0020, 0x0040, 0x0100, 0x00A0, with `s_last` on beat 99 →
  - `gb_we` high 100 consecutive cycles, addresses 0..99, data matching the pattern;
  - `start` pulses exactly once, 1 cycle after the addr-99 write;
  - `err_len`=0.
- Handshake: `done` held low for 50 cycles after `start` → `s_ready`=0 throughout and `s_valid` is ignored. Pulse `done` → `s_ready`=1 next cycle and a second frame writes again from address 0.
- Short frame: 60 beats with `s_last` on beat 59 →
  - addresses 60..99 written with 0x0000;
  - `err_len`=1;
  - `start` after the addr-99 write.
- Long/missing last: 100 beats with `s_last`=0 throughout → `err_len`=1 and `start` fires. The 101st word is not accepted until `done`.
- Mid-frame reset: assert `rst` after 37 beats → next cycle `s_ready`=1, `gb_we`=0, `start` never fires. A fresh 100-beat frame then completes cleanly from address 0.
